// File: rtl/relm_push_arb.sv
// relm_push_arb: round-robin arbiter sharing one push-port device among NREQ
// relm push ports. Each requester owns a one-entry holding slot; the device
// sees one registered {strobe, data} word plus the owning requester index.

// One requester's holding slot: captures a push when empty and reports a
// retry when a push arrives while still occupied.
module relm_push_slot #(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stb_i,
  input  logic [WD-1:0] data_i,
  input  logic          clr_i,
  output logic          full_o,
  output logic [WD-1:0] hold_o,
  output logic          retry_o
);
  logic          full_q;
  logic [WD-1:0] hold_q;

  // Accept into an empty slot, or release on grant. A grant needs full_q set,
  // so both can never apply to the same slot in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      hold_q <= '0;
    end else if (stb_i && !full_q) begin
      full_q <= 1'b1;
      hold_q <= data_i;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end

  // Retry looks only at the registered occupancy, so a slot draining this
  // cycle still refuses this cycle's push.
  assign retry_o = stb_i & full_q;
  assign full_o  = full_q;
  assign hold_o  = hold_q;
endmodule

module relm_push_arb #(
  parameter int WD   = 32,
  parameter int NREQ = 3,
  parameter int WSEL = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ*(WD+1)-1:0]   push_in,
  output logic [NREQ-1:0]          retry_out,
  output logic [NREQ-1:0]          busy_out,
  output logic [WD:0]              dev_out,
  output logic [WSEL-1:0]          dev_id_out,
  input  logic                     dev_retry_in
);
  logic [NREQ-1:0]         full;
  logic [NREQ-1:0][WD-1:0] hold;
  logic [NREQ-1:0]         gnt_oh;
  logic [NREQ-1:0]         ge_mask;
  logic [NREQ-1:0]         cand;
  logic [WSEL-1:0]         gnt_idx;
  logic [WSEL-1:0]         gnt_ptr;
  logic [WD-1:0]           gnt_data;
  logic                    found;
  logic                    consumed;
  logic                    load;

  logic                    ov_q;
  logic [WD-1:0]           od_q;
  logic [WSEL-1:0]         oid_q;
  logic [WSEL-1:0]         ptr_q;

  assign consumed = ov_q & ~dev_retry_in;
  assign load     = (~ov_q | consumed) & (|full);

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    relm_push_slot #(.WD(WD)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .stb_i   (push_in[(WD+1)*i+WD]),
      .data_i  (push_in[(WD+1)*i +: WD]),
      .clr_i   (load & gnt_oh[i]),
      .full_o  (full[i]),
      .hold_o  (hold[i]),
      .retry_o (retry_out[i])
    );
  end

  // Circular search from ptr: prefer full slots at or above ptr, otherwise
  // wrap to the lowest full slot.
  always_comb begin
    ge_mask = '0;
    for (int i = 0; i < NREQ; i++) ge_mask[i] = (i >= int'(ptr_q));
    cand     = (|(full & ge_mask)) ? (full & ge_mask) : full;
    gnt_oh   = '0;
    gnt_idx  = '0;
    gnt_ptr  = '0;
    gnt_data = '0;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand[i] && !found) begin
        found     = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_idx   = WSEL'(i);
        gnt_ptr   = (i + 1 == NREQ) ? '0 : WSEL'(i + 1);
        gnt_data  = hold[i];
      end
    end
  end

  // Output stage: load the granted word when free or just consumed; a refused
  // word holds everything, including the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      od_q  <= '0;
      oid_q <= '0;
      ptr_q <= '0;
    end else if (load) begin
      ov_q  <= 1'b1;
      od_q  <= gnt_data;
      oid_q <= gnt_idx;
      ptr_q <= gnt_ptr;
    end else if (consumed) begin
      ov_q  <= 1'b0;
    end
  end

  assign dev_out    = {ov_q, od_q};
  assign dev_id_out = oid_q;
  assign busy_out   = full;
endmodule

// File: tb/tb_relm_push_arb.sv
// Bench for relm_push_arb: cycle model of the holding slots and output word,
// a scoreboard of granted words, and a monitor that pops on each delivery.
module tb_relm_push_arb;
  localparam int WD = 32, NREQ = 3, WSEL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NREQ*(WD+1)-1:0] push_in = '0;
  logic [NREQ-1:0]        retry_out, busy_out;
  logic [WD:0]            dev_out;
  logic [WSEL-1:0]        dev_id_out;
  logic                   dev_retry_in = 1'b0;

  always #5 clk = ~clk;

  relm_push_arb #(.WD(WD), .NREQ(NREQ), .WSEL(WSEL)) dut (
    .clk(clk), .rst_n(rst_n), .push_in(push_in), .retry_out(retry_out),
    .busy_out(busy_out), .dev_out(dev_out), .dev_id_out(dev_id_out),
    .dev_retry_in(dev_retry_in)
  );

  int pass_cnt = 0, tot_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference state: what each requester's slot holds and which word is offered.
  bit             mfull[NREQ];
  logic [WD-1:0]  mhold[NREQ];
  bit             mov;
  logic [WD-1:0]  mod;
  int             moid, mptr;

  typedef struct { logic [WD-1:0] d; int id; } exp_t;
  exp_t expq[$];

  bit fair_mode = 0;
  int last_id = -1;
  logic [NREQ-1:0] last_retry;

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin mfull[i] = 0; mhold[i] = '0; end
    mov = 0; mod = '0; moid = 0; mptr = 0;
    expq.delete();
  endtask

  // One cycle: drive at negedge, check outputs, then advance the model to the
  // next rising edge.
  task automatic step(input logic [NREQ-1:0] s, input logic [NREQ-1:0][WD-1:0] d, input logic r);
    logic [NREQ-1:0] exp_retry, exp_busy;
    bit of[NREQ];
    bit cons, anyf;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) push_in[(WD+1)*i +: WD+1] = {s[i], d[i]};
    dev_retry_in = r;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      exp_retry[i] = s[i] & mfull[i];
      exp_busy[i]  = mfull[i];
    end
    chk("retry_out", 64'(retry_out), 64'(exp_retry));
    chk("busy_out", 64'(busy_out), 64'(exp_busy));
    chk("dev_strobe", 64'(dev_out[WD]), 64'(mov));
    if (mov) begin
      chk("dev_data", 64'(dev_out[WD-1:0]), 64'(mod));
      chk("dev_id", 64'(dev_id_out), 64'(moid));
    end
    last_retry = retry_out;
    for (int i = 0; i < NREQ; i++) of[i] = mfull[i];
    cons = mov && !r;
    anyf = 0;
    for (int i = 0; i < NREQ; i++) anyf |= of[i];
    if ((!mov || cons) && anyf) begin
      for (int k = 0; k < NREQ; k++) begin
        int g;
        g = (mptr + k) % NREQ;
        if (of[g]) begin
          mod = mhold[g]; moid = g; mov = 1; mfull[g] = 0;
          mptr = (g + 1) % NREQ;
          e.d = mhold[g]; e.id = g;
          expq.push_back(e);
          break;
        end
      end
    end else if (cons) begin
      mov = 0;
    end
    for (int i = 0; i < NREQ; i++)
      if (s[i] && !of[i]) begin mfull[i] = 1; mhold[i] = d[i]; end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0);
  endtask

  // Monitor: every delivered word (strobe high, not refused) must be the
  // oldest outstanding grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && dev_out[WD] && !dev_retry_in) begin
        if (expq.size() == 0) begin
          chk("unexpected_word", 64'(dev_out[WD-1:0]), 64'hdead_0000);
        end else begin
          e = expq.pop_front();
          chk("deliver_data", 64'(dev_out[WD-1:0]), 64'(e.d));
          chk("deliver_id", 64'(dev_id_out), 64'(e.id));
          if (fair_mode && last_id >= 0)
            chk("fair_seq", 64'(dev_id_out), 64'((last_id + 1) % NREQ));
          last_id = int'(dev_id_out);
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0][WD-1:0] d;
    logic [NREQ-1:0][WD-1:0] pd;
    logic [NREQ-1:0] s;
    int cnt;
    model_reset();
    // Reset: outputs cleared and no retry regardless of inputs.
    for (int i = 0; i < NREQ; i++) push_in[(WD+1)*i +: WD+1] = {1'b1, 32'(32'h100 + i)};
    #2;
    chk("rst_retry", 64'(retry_out), 64'h0);
    chk("rst_dev_out", 64'(dev_out), 64'h0);
    chk("rst_dev_id", 64'(dev_id_out), 64'h0);
    chk("rst_busy", 64'(busy_out), 64'h0);
    @(negedge clk);
    push_in = '0;
    rst_n = 1'b1;
    idle(2);

    // Single push from requester 1.
    d = '0; d[1] = 32'h41;
    step(3'b010, d, 1'b0);
    step('0, '0, 1'b0);
    chk("single_busy_t1", 64'(busy_out), 64'h2);
    step('0, '0, 1'b0);
    chk("single_dev_t2", 64'(dev_out), {31'h0, 1'b1, 32'h41});
    chk("single_id_t2", 64'(dev_id_out), 64'h1);
    step('0, '0, 1'b0);
    chk("single_one_cycle", 64'(dev_out[WD]), 64'h0);
    idle(2);

    // Simultaneous pushes.
    d[0] = 32'hA0; d[1] = 32'hA1; d[2] = 32'hA2;
    step(3'b111, d, 1'b0);
    idle(5);

    // Back-pressure on requester 2's word with pushes during the stall.
    d = '0; d[2] = 32'h55;
    step(3'b100, d, 1'b0);
    step('0, '0, 1'b0);
    d[2] = 32'h66; step(3'b100, d, 1'b1);
    d[2] = 32'h77; step(3'b100, d, 1'b1);
    for (int k = 0; k < 3; k++) step('0, '0, 1'b1);
    idle(4);

    // Two consecutive pushes from requester 0.
    d = '0; d[0] = 32'h10;
    step(3'b001, d, 1'b0);
    d[0] = 32'h11;
    step(3'b001, d, 1'b0);
    idle(4);

    // Fairness: every requester pushes every cycle, reissuing refused words.
    cnt = 32'h200;
    for (int i = 0; i < NREQ; i++) begin pd[i] = 32'(cnt); cnt++; end
    fair_mode = 1; last_id = -1;
    for (int k = 0; k < 30; k++) begin
      step(3'b111, pd, 1'b0);
      for (int i = 0; i < NREQ; i++)
        if (!last_retry[i]) begin pd[i] = 32'(cnt); cnt++; end
    end
    fair_mode = 0;
    idle(6);

    // Random traffic with random device back-pressure.
    for (int k = 0; k < 300; k++) begin
      s = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) d[i] = $urandom;
      step(s, d, ($urandom_range(0, 9) < 3));
    end
    idle(8);

    // Reset mid-operation: word offered and two slots full.
    d[0] = 32'hC0; d[1] = 32'hC1; d[2] = 32'hC2;
    step(3'b011, d, 1'b0);
    step(3'b100, d, 1'b1);
    @(negedge clk);
    #2;
    chk("pre_rst_ov", 64'(dev_out[WD]), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dev_out", 64'(dev_out), 64'h0);
    chk("mid_rst_busy", 64'(busy_out), 64'h0);
    model_reset();
    push_in = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    d = '0; d[1] = 32'h99;
    step(3'b010, d, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("post_rst_dev_t2", 64'(dev_out), {31'h0, 1'b1, 32'h99});
    idle(4);

    chk("scoreboard_empty", 64'(expq.size()), 64'h0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
